// File: rtl/qrisc_mem_arbiter.sv
// Single-port memory arbiter between Qrisc32 instruction fetch and data access.
// Optional wait-cycle timeout with sticky err flag is enabled by defining MEM_TIMEOUT_EN.
module qrisc_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          areset_n,
    // fetch port
    input  logic          ibus_req,
    input  logic [AW-1:0] ibus_addr,
    output logic          ibus_ack,
    output logic [DW-1:0] ibus_rdata,
    // data port
    input  logic          dbus_req,
    input  logic          dbus_we,
    input  logic [AW-1:0] dbus_addr,
    input  logic [DW-1:0] dbus_wdata,
    output logic          dbus_ack,
    output logic [DW-1:0] dbus_rdata,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    // status and debug
    output logic          grant_d,
    output logic          err,
    output logic [2:0]    o_dbg_state,
    output logic [3:0]    o_dbg_starve_cnt
);

    // Handshake: a requester raises x_req and holds it with stable inputs until
    // x_ack; x_ack is a one-cycle pulse with x_rdata valid; the memory side sees
    // mem_req held with stable mem_* until a one-cycle mem_ack.

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("qrisc_mem_arbiter: MAX_STARVE must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("qrisc_mem_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4
    } state_t;

    localparam logic [3:0] LP_MAX_STARVE = 4'(MAX_STARVE);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_starve_cnt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_ibus_rdata;
    logic [DW-1:0] r_dbus_rdata;

    logic w_busy;
    logic w_grant_i;
    logic w_grant_d;
    logic w_complete;
    logic w_abandon;
    logic w_wait_expired;

    assign w_busy = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_complete  = 1'b0;
        w_abandon   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data wins contention until fetch has watched MAX_STARVE data grants.
                if (dbus_req && ibus_req) begin
                    if (r_starve_cnt == LP_MAX_STARVE) w_grant_i = 1'b1;
                    else                               w_grant_d = 1'b1;
                end else if (dbus_req) begin
                    w_grant_d = 1'b1;
                end else if (ibus_req) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d)      w_state_nxt = S_BUSY_D;
                else if (w_grant_i) w_state_nxt = S_BUSY_I;
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ack)             w_complete = 1'b1;
                else if (w_wait_expired) w_abandon  = 1'b1;
                if (w_complete || w_abandon)
                    w_state_nxt = (r_state == S_BUSY_I) ? S_DONE_I : S_DONE_D;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_starve_cnt <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (w_grant_i) begin
            r_starve_cnt <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= ibus_addr;
            r_mem_wdata  <= '0;
        end else if (w_grant_d) begin
            // Contended data grants only happen below the limit, so this saturates.
            if (ibus_req) r_starve_cnt <= r_starve_cnt + 4'd1;
            r_mem_we    <= dbus_we;
            r_mem_addr  <= dbus_addr;
            r_mem_wdata <= dbus_wdata;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_ibus_rdata <= '0;
            r_dbus_rdata <= '0;
        end else if (w_complete) begin
            if (r_state == S_BUSY_I) r_ibus_rdata <= mem_rdata;
            else                     r_dbus_rdata <= r_mem_we ? '0 : mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_abandon) begin
            if (r_state == S_BUSY_I) r_ibus_rdata <= DW'(32'hDEAD_BEEF);
            else                     r_dbus_rdata <= DW'(32'hDEAD_BEEF);
        end
`endif
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;
    logic       r_err;

    // The last allowed wait cycle is the one where the counter shows TIMEOUT-1.
    assign w_wait_expired = (r_wait_cnt == LP_WAIT_LAST);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant_i || w_grant_d)  r_wait_cnt <= '0;
            else if (w_busy && !mem_ack) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_abandon) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wait_expired = 1'b0;
    assign err            = 1'b0;
`endif

    assign mem_req          = w_busy;
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_wdata        = r_mem_wdata;
    assign grant_d          = (r_state == S_BUSY_D);
    assign ibus_ack         = (r_state == S_DONE_I);
    assign dbus_ack         = (r_state == S_DONE_D);
    assign ibus_rdata       = r_ibus_rdata;
    assign dbus_rdata       = r_dbus_rdata;
    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_qrisc_mem_arbiter.sv
// Bench for qrisc_mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of the arbitration rules (MEM_TIMEOUT_EN aware).
module tb_qrisc_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STARVE = 3;
    localparam int TIMEOUT    = 8;
    localparam int P_IDLE     = 0;
    localparam int P_BUSY     = 1;
    localparam int P_DONE     = 2;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          ibus_req = 1'b0;
    logic [AW-1:0] ibus_addr = '0;
    logic          ibus_ack;
    logic [DW-1:0] ibus_rdata;
    logic          dbus_req = 1'b0;
    logic          dbus_we = 1'b0;
    logic [AW-1:0] dbus_addr = '0;
    logic [DW-1:0] dbus_wdata = '0;
    logic          dbus_ack;
    logic [DW-1:0] dbus_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          grant_d;
    logic          err;
    logic [2:0]    o_dbg_state;
    logic [3:0]    o_dbg_starve_cnt;

    always #5 clk = ~clk;

    qrisc_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .areset_n(areset_n),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant_d(grant_d), .err(err),
        .o_dbg_state(o_dbg_state), .o_dbg_starve_cnt(o_dbg_starve_cnt)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dreq_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] i_dir_q[$];
    dreq_t         d_dir_q[$];
    int            grant_log[$];
    int            starve_log[$];
    int            d_ack_cyc[$];

    bit            i_pend, d_pend, err_m, rand_en, spur_en, force_rdata_en;
    logic [AW-1:0] i_addr;
    dreq_t         d_cur;
    int            phase, owner, lat, busy_cycles, starve, force_lat;
    logic [DW-1:0] force_rdata, i_rdata_m, d_rdata_m, g_wdata;
    logic [AW-1:0] g_addr;
    logic          g_we;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase = P_IDLE; starve = 0; err_m = 1'b0; lat = 0; busy_cycles = 0;
        i_rdata_m = '0; d_rdata_m = '0; i_pend = 1'b0; d_pend = 1'b0;
        exp_q.delete(); i_dir_q.delete(); d_dir_q.delete();
    endtask

    task automatic drive_pins();
        ibus_req   = i_pend;
        ibus_addr  = i_pend ? i_addr : $urandom;
        dbus_req   = d_pend;
        dbus_we    = d_pend ? d_cur.we : 1'($urandom);
        dbus_addr  = d_pend ? d_cur.addr : $urandom;
        dbus_wdata = d_pend ? d_cur.wdata : $urandom;
    endtask

    // One clock: apply the arbitration rules to what the DUT sampled at the
    // previous rising edge, compare every output, then drive the next inputs.
    task automatic step();
        logic          ireq_s, dreq_s, ack_s;
        logic [DW-1:0] rdata_s, e;
        @(negedge clk);
        cyc++;
        ireq_s = ibus_req; dreq_s = dbus_req; ack_s = mem_ack; rdata_s = mem_rdata;
        case (phase)
            P_IDLE: if (ireq_s || dreq_s) begin
                if (ireq_s && (!dreq_s || starve >= MAX_STARVE)) begin
                    owner = 0; starve = 0;
                    g_addr = ibus_addr; g_we = 1'b0; g_wdata = '0;
                end else begin
                    owner = 1;
                    if (ireq_s && starve < MAX_STARVE) starve++;
                    g_addr = dbus_addr; g_we = dbus_we; g_wdata = dbus_wdata;
                end
                phase = P_BUSY; busy_cycles = 1;
                lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                grant_log.push_back(owner);
                starve_log.push_back(starve);
            end
            P_BUSY: begin
                if (ack_s) begin
                    exp_q.push_back((owner == 1 && g_we) ? '0 : rdata_s);
                    phase = P_DONE;
                end else if (TO_EN && busy_cycles == TIMEOUT) begin
                    exp_q.push_back(32'hDEAD_BEEF);
                    err_m = 1'b1;
                    phase = P_DONE;
                end else begin
                    busy_cycles++;
                end
            end
            default: phase = P_IDLE;
        endcase
        if (phase == P_DONE && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (owner == 0) i_rdata_m = e;
            else            d_rdata_m = e;
        end

        check("mem_req", mem_req, phase == P_BUSY);
        check("grant_d", grant_d, phase == P_BUSY && owner == 1);
        check("ibus_ack", ibus_ack, phase == P_DONE && owner == 0);
        check("dbus_ack", dbus_ack, phase == P_DONE && owner == 1);
        check("ibus_rdata", ibus_rdata, i_rdata_m);
        check("dbus_rdata", dbus_rdata, d_rdata_m);
        check("err", err, err_m);
        check("starve_cnt", o_dbg_starve_cnt, starve);
        if (phase == P_BUSY) begin
            check("mem_addr", mem_addr, g_addr);
            check("mem_we", mem_we, g_we);
            check("mem_wdata", mem_wdata, g_wdata);
        end

        if (phase == P_DONE) begin
            if (owner == 0) i_pend = 1'b0;
            else begin d_pend = 1'b0; d_ack_cyc.push_back(cyc); end
        end
        if (!i_pend) begin
            if (i_dir_q.size() > 0) begin
                i_addr = i_dir_q.pop_front(); i_pend = 1'b1;
            end else if (rand_en && $urandom_range(0, 2) == 0) begin
                i_addr = $urandom & 32'hFFFF_FFFC; i_pend = 1'b1;
            end
        end
        if (!d_pend) begin
            if (d_dir_q.size() > 0) begin
                d_cur = d_dir_q.pop_front(); d_pend = 1'b1;
            end else if (rand_en && $urandom_range(0, 2) == 0) begin
                d_cur.we = 1'($urandom); d_cur.addr = $urandom & 32'hFFFF_FFFC;
                d_cur.wdata = $urandom; d_pend = 1'b1;
            end
        end
        drive_pins();

        if (phase == P_BUSY) begin
            if (lat == 0) begin
                mem_ack = 1'b1;
                mem_rdata = force_rdata_en ? force_rdata : $urandom;
            end else begin
                lat--;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            mem_ack = spur_en && ($urandom_range(0, 5) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n = 0;
        while ((i_pend || d_pend || phase != P_IDLE || i_dir_q.size() > 0 || d_dir_q.size() > 0)
               && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_finished"}, (n < max_cycles), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[8];
        int exp_starve[8];
        exp_order  = '{1, 1, 1, 0, 1, 1, 1, 0};
        exp_starve = '{1, 2, 3, 0, 1, 2, 3, 0};
        model_reset();
        force_lat = -1; force_rdata_en = 1'b0; rand_en = 1'b0; spur_en = 1'b0;
        force_rdata = '0;

        // reset: requests asserted must not leak through
        ibus_req = 1'b1; dbus_req = 1'b1; mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_acks", {ibus_ack, dbus_ack, grant_d, err}, 0);
        check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", {ibus_rdata, dbus_rdata}, 0);
        check("rst_starve", o_dbg_starve_cnt, 0);
        drive_pins(); mem_ack = 1'b0;
        areset_n = 1'b1;

        // single fetch, memory answers on the second busy cycle
        force_lat = 1; force_rdata_en = 1'b1; force_rdata = 32'h4000_0021;
        i_dir_q.push_back(32'h100);
        run_until_idle("single_fetch", 20);
        check("single_fetch_rdata", ibus_rdata, 32'h4000_0021);

        // data store
        force_rdata = 32'h1234_5678;
        d_dir_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hCAFE_F00D});
        run_until_idle("store", 20);
        check("store_rdata", dbus_rdata, 0);
        force_rdata_en = 1'b0;

        // contention with both ports held continuously
        grant_log.delete(); starve_log.delete();
        force_lat = $urandom_range(0, 2);
        for (int i = 0; i < 2; i++) i_dir_q.push_back(32'h1000 + 4 * i);
        for (int i = 0; i < 6; i++)
            d_dir_q.push_back('{we: 1'($urandom), addr: 32'h2000 + 4 * i, wdata: $urandom});
        run_until_idle("contention", 120);
        for (int i = 0; i < 8; i++) begin
            check("contention_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            check("contention_starve", (i < starve_log.size()) ? starve_log[i] : -1, exp_starve[i]);
        end

        // back-to-back loads with immediate memory response
        force_lat = 0; d_ack_cyc.delete();
        for (int i = 0; i < 3; i++) d_dir_q.push_back('{we: 1'b0, addr: 4 * i, wdata: '0});
        run_until_idle("b2b", 30);
        check("b2b_count", d_ack_cyc.size(), 3);
        for (int i = 1; i < d_ack_cyc.size(); i++)
            check("b2b_gap", d_ack_cyc[i] - d_ack_cyc[i-1], 3);

`ifdef MEM_TIMEOUT_EN
        // ack arriving on the last allowed wait cycle still completes normally
        force_lat = TIMEOUT - 1;
        d_dir_q.push_back('{we: 1'b0, addr: 32'h80, wdata: '0});
        run_until_idle("ack_at_limit", 40);
        check("ack_at_limit_err", err, 0);
        // no response at all: abandoned after TIMEOUT busy cycles
        force_lat = 1000;
        d_dir_q.push_back('{we: 1'b0, addr: 32'h84, wdata: '0});
        run_until_idle("timeout", 40);
        check("timeout_rdata", dbus_rdata, 32'hDEAD_BEEF);
        check("timeout_err", err, 1);
        repeat (5) step();
        check("timeout_err_sticky", err, 1);
`endif

        // reset in the middle of a data transaction
        force_lat = 1000;
        d_dir_q.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
        repeat (3) step();
        #2 areset_n = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_acks", {dbus_ack, ibus_ack, grant_d}, 0);
        model_reset();
        drive_pins(); mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        repeat (4) step();
        check("state_idle_after_rst", o_dbg_state, 0);

        // randomized traffic, spurious mem_ack while not busy
        force_lat = -1; rand_en = 1'b1; spur_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        run_until_idle("drain", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
